iq_gain_sequencer: RTL and testbench

- Sequencer that drives the four gain inputs (g1..g4) of one IQ modulator block.
- Ramps each gain from its current value to a CPU-written target in bounded steps, so the modulator output has no amplitude or offset jumps.
- Sits between the register bank and the modulator. One shared add/compare datapath, time-multiplexed round-robin over the four channels.

---
 rtl/iq_gain_sequencer.sv | 155 +++++++++++++++
 tb/tb_iq_gain_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iq_gain_sequencer.sv
// Ramps the four IQ modulator gains toward CPU-written targets in bounded steps,
// using one shared datapath visited round-robin. Define IQ_GAIN_SEQ_HOLD_EN to add hold_i.
module iq_gain_sequencer #(
  parameter int GAINBITS = 16,
  parameter int DIVBITS  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [3:0]                 target_we_i,
  input  logic signed [GAINBITS-1:0] target_i,
  input  logic [GAINBITS-1:0]        step_i,
  input  logic [DIVBITS-1:0]         div_i,
  input  logic                       start_i,
  input  logic                       abort_i,
`ifdef IQ_GAIN_SEQ_HOLD_EN
  input  logic                       hold_i,
`endif
  output logic signed [GAINBITS-1:0] g1_o,
  output logic signed [GAINBITS-1:0] g2_o,
  output logic signed [GAINBITS-1:0] g3_o,
  output logic signed [GAINBITS-1:0] g4_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [3:0]                 ch_active_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAMP = 2'd1, S_DONE = 2'd2} state_t;

  state_t                     state_r, state_nx;
  logic [DIVBITS-1:0]         presc_r, presc_nx;
  logic [1:0]                 ptr_r, ptr_nx;
  logic signed [GAINBITS-1:0] gain_r   [4];
  logic signed [GAINBITS-1:0] target_r [4];
  logic                       all_eq_r;
  logic                       busy_r, done_r;
  logic [3:0]                 ch_active_r;
  logic                       tick_s, upd_s, hold_s, eq_s;

  // One step of gain cur toward tgt; the result never passes tgt, so no overflow.
  function automatic logic signed [GAINBITS-1:0] step_toward(
    input logic signed [GAINBITS-1:0] cur,
    input logic signed [GAINBITS-1:0] tgt,
    input logic [GAINBITS-1:0]        step
  );
    logic signed [GAINBITS:0] diff;
    logic [GAINBITS:0]        mag;
    logic signed [GAINBITS:0] sum;
    diff = {tgt[GAINBITS-1], tgt} - {cur[GAINBITS-1], cur};
    mag  = diff[GAINBITS] ? -diff : diff;
    if ((step == {GAINBITS{1'b0}}) || (mag <= {1'b0, step})) begin
      sum = {tgt[GAINBITS-1], tgt};
    end else if (diff[GAINBITS]) begin
      sum = {cur[GAINBITS-1], cur} - {1'b0, step};
    end else begin
      sum = {cur[GAINBITS-1], cur} + {1'b0, step};
    end
    return sum[GAINBITS-1:0];
  endfunction

`ifdef IQ_GAIN_SEQ_HOLD_EN
  assign hold_s = hold_i;
`else
  assign hold_s = 1'b0;
`endif

  assign tick_s = (presc_r >= div_i);
  assign eq_s   = (gain_r[0] == target_r[0]) && (gain_r[1] == target_r[1]) &&
                  (gain_r[2] == target_r[2]) && (gain_r[3] == target_r[3]);

  // Next-state, prescaler and pointer logic; abort outranks everything else.
  always_comb begin
    state_nx = state_r;
    presc_nx = presc_r;
    ptr_nx   = ptr_r;
    upd_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (abort_i) begin
          state_nx = S_IDLE;
        end else if (start_i) begin
          state_nx = S_RAMP;
          presc_nx = {DIVBITS{1'b0}};
          ptr_nx   = 2'd0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RAMP: begin
        if (abort_i) begin
          state_nx = S_IDLE;
        end else if (hold_s) begin
          state_nx = S_RAMP;
        end else begin
          state_nx = all_eq_r ? S_DONE : S_RAMP;
          if (tick_s) begin
            upd_s    = 1'b1;
            presc_nx = {DIVBITS{1'b0}};
            ptr_nx   = ptr_r + 2'd1;
          end else begin
            presc_nx = presc_r + {{(DIVBITS-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, gains, targets and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      presc_r     <= {DIVBITS{1'b0}};
      ptr_r       <= 2'd0;
      all_eq_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ch_active_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        gain_r[k]   <= {GAINBITS{1'b0}};
        target_r[k] <= {GAINBITS{1'b0}};
      end
    end else begin
      state_r <= state_nx;
      presc_r <= presc_nx;
      ptr_r   <= ptr_nx;
      for (int k = 0; k < 4; k++) begin
        if (target_we_i[k]) begin
          target_r[k] <= target_i;
        end
      end
      if (upd_s) begin
        gain_r[ptr_r] <= step_toward(gain_r[ptr_r], target_r[ptr_r], step_i);
      end
      // A target write makes the registered compare stale, so it is forced low.
      all_eq_r    <= eq_s && (target_we_i == 4'b0000);
      busy_r      <= (state_nx == S_RAMP);
      done_r      <= (state_nx == S_DONE);
      ch_active_r <= (state_nx == S_RAMP) ? (4'b0001 << ptr_nx) : 4'b0000;
    end
  end

  assign g1_o        = gain_r[0];
  assign g2_o        = gain_r[1];
  assign g3_o        = gain_r[2];
  assign g4_o        = gain_r[3];
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign ch_active_o = ch_active_r;

endmodule

// File: tb/tb_iq_gain_sequencer.sv
// Scoreboard bench for iq_gain_sequencer: expected gain-change/done events are queued by
// the stimulus and checked (value and cycle gap) by an independent monitor.
module tb_iq_gain_sequencer;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [3:0]         target_we_i;
  logic signed [15:0] target_i;
  logic [15:0]        step_i;
  logic [15:0]        div_i;
  logic               start_i, abort_i;
  logic signed [15:0] g1_o, g2_o, g3_o, g4_o;
  logic               busy_o, done_o;
  logic [3:0]         ch_active_o;

  iq_gain_sequencer #(.GAINBITS(16), .DIVBITS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .target_we_i(target_we_i), .target_i(target_i),
    .step_i(step_i), .div_i(div_i), .start_i(start_i), .abort_i(abort_i),
    .g1_o(g1_o), .g2_o(g2_o), .g3_o(g3_o), .g4_o(g4_o),
    .busy_o(busy_o), .done_o(done_o), .ch_active_o(ch_active_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  logic [64:0] exp_q [$];
  int          gap_q [$];
  logic [63:0] prev_g;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", name, got, exp);
    else n_pass++;
  endtask

  task automatic push(input int a, input int b, input int c, input int d, input bit dn, input int gap);
    logic signed [15:0] ga, gb, gc, gd;
    ga = a[15:0]; gb = b[15:0]; gc = c[15:0]; gd = d[15:0];
    exp_q.push_back({dn, ga, gb, gc, gd});
    gap_q.push_back(gap);
  endtask

  // Monitor: every gain change or done pulse is an output event checked against the queue.
  always @(negedge clk_i) begin
    logic [64:0] cur, e;
    int gp;
    cyc++;
    cur = {done_o, g1_o, g2_o, g3_o, g4_o};
    if (rst_i) begin
      prev_g   = cur[63:0];
      last_cyc = cyc;
    end else if (done_o || (cur[63:0] != prev_g)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event got=%h expected=none", cur);
      end else begin
        e  = exp_q.pop_front();
        gp = gap_q.pop_front();
        chk("event_value", cur, e);
        if (gp != 0) chk("event_gap", 65'(cyc - last_cyc), 65'(gp));
      end
      last_cyc = cyc;
      prev_g   = cur[63:0];
    end
  end

  task automatic tick1();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick1(); tick1(); rst_i = 1'b0;
  endtask

  task automatic write_t(input int k, input int v);
    target_we_i = 4'b0001 << k; target_i = v[15:0]; tick1(); target_we_i = 4'b0000;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick1(); start_i = 1'b0;
  endtask

  task automatic wait_g1(input int v);
    logic signed [15:0] want;
    want = v[15:0];
    for (int i = 0; i < 500 && g1_o !== want; i++) tick1();
    chk("wait_g1", 65'(g1_o), 65'(want));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy_o); i++) tick1();
    chk("drain_empty", 65'(exp_q.size()), 65'd0);
    tick1(); tick1();
  endtask

  initial begin
    target_we_i = 4'b0000; target_i = 16'sd0; step_i = 16'd0; div_i = 16'd0;
    start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b1;
    tick1(); tick1(); tick1(); rst_i = 1'b0;

    // Reset state
    chk("rst_gains", {1'b0, g1_o, g2_o, g3_o, g4_o}, 65'd0);
    chk("rst_busy", 65'(busy_o), 65'd0);
    chk("rst_done", 65'(done_o), 65'd0);
    chk("rst_ch_active", 65'(ch_active_o), 65'd0);

    // Ramp ch0 to 1000, step 100, tick every cycle
    write_t(0, 1000); div_i = 16'd0; step_i = 16'd100;
    push(100, 0, 0, 0, 0, 0);
    for (int v = 200; v <= 1000; v += 100) push(v, 0, 0, 0, 0, 4);
    push(1000, 0, 0, 0, 1, 2);
    pulse_start();
    chk("ramp_busy", 65'(busy_o), 65'd1);
    chk("ch_active_first", 65'(ch_active_o), 65'd1);
    tick1();
    chk("ch_active_second", 65'(ch_active_o), 65'd2);
    drain();

    // ch1 to -1000, step 300, div 3: clamped final step, update every 16 cycles
    write_t(1, -1000); div_i = 16'd3; step_i = 16'd300;
    push(1000, -300, 0, 0, 0, 0);
    push(1000, -600, 0, 0, 0, 16);
    push(1000, -900, 0, 0, 0, 16);
    push(1000, -1000, 0, 0, 0, 16);
    push(1000, -1000, 0, 0, 1, 2);
    pulse_start();
    drain();

    // step 0: every channel jumps on its first tick
    write_t(0, 5); write_t(1, -5); write_t(2, 7); write_t(3, -7);
    div_i = 16'd0; step_i = 16'd0;
    push(5, -1000, 0, 0, 0, 0);
    push(5, -5, 0, 0, 0, 1);
    push(5, -5, 7, 0, 0, 1);
    push(5, -5, 7, -7, 0, 1);
    push(5, -5, 7, -7, 1, 2);
    pulse_start();
    drain();

    // Reset clears targets: start with everything equal gives an immediate done
    do_reset();
    chk("rst2_gains", {1'b0, g1_o, g2_o, g3_o, g4_o}, 65'd0);
    tick1();
    push(0, 0, 0, 0, 1, 0);
    pulse_start();
    drain();

    // Abort at 500 freezes the gain without done, a new start resumes
    write_t(0, 1000); div_i = 16'd0; step_i = 16'd100;
    for (int v = 100; v <= 500; v += 100) push(v, 0, 0, 0, 0, (v == 100) ? 0 : 4);
    pulse_start();
    wait_g1(500);
    abort_i = 1'b1; tick1(); abort_i = 1'b0;
    chk("abort_busy", 65'(busy_o), 65'd0);
    chk("abort_ch_active", 65'(ch_active_o), 65'd0);
    for (int i = 0; i < 12; i++) tick1();
    chk("abort_frozen", 65'(g1_o), 65'(16'sd500));
    push(600, 0, 0, 0, 0, 0);
    for (int v = 700; v <= 1000; v += 100) push(v, 0, 0, 0, 0, 4);
    push(1000, 0, 0, 0, 1, 2);
    pulse_start();
    drain();

    // Live target rewrite mid-ramp: 1000 -> 200 while g1=600
    do_reset();
    write_t(0, 1000);
    for (int v = 100; v <= 600; v += 100) push(v, 0, 0, 0, 0, (v == 100) ? 0 : 4);
    for (int v = 500; v >= 200; v -= 100) push(v, 0, 0, 0, 0, 4);
    push(200, 0, 0, 0, 1, 2);
    pulse_start();
    wait_g1(600);
    write_t(0, 200);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
